// File: rtl/register_file.sv
// 32-entry RV32I general-purpose register file: two combinational read ports,
// one synchronous write port, x0 reads as zero, sp/gp preloaded on reset.
module register_file #(
    parameter int                  DATA_LENGTH = 32,
    parameter int                  ADDR_LENGTH = 5,
    parameter logic [DATA_LENGTH-1:0] SP_RESET = 32'h7FFF_EFFC,
    parameter logic [DATA_LENGTH-1:0] GP_RESET = 32'h1000_8000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_write,
    input  logic [ADDR_LENGTH-1:0] write_reg,
    input  logic [DATA_LENGTH-1:0] write_data,
    input  logic [ADDR_LENGTH-1:0] read_reg1,
    input  logic [ADDR_LENGTH-1:0] read_reg2,
    output logic [DATA_LENGTH-1:0] read_data1,
    output logic [DATA_LENGTH-1:0] read_data2
);

    localparam int DEPTH = 2 ** ADDR_LENGTH;

    logic [DATA_LENGTH-1:0] regs_q [DEPTH];
    logic [DATA_LENGTH-1:0] regs_d [DEPTH];

    // Next-state: a single write per cycle, never into x0.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != {ADDR_LENGTH{1'b0}})) begin
            regs_d[write_reg] = write_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // State update; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {DATA_LENGTH{1'b0}};
            end
            regs_q[2] <= SP_RESET;
            regs_q[3] <= GP_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: no write bypass, and x0 gated here so an unknown write enable cannot leak into it.
    always_comb begin
        if (read_reg1 == {ADDR_LENGTH{1'b0}}) begin
            read_data1 = {DATA_LENGTH{1'b0}};
        end else begin
            read_data1 = regs_q[read_reg1];
        end
        if (read_reg2 == {ADDR_LENGTH{1'b0}}) begin
            read_data2 = {DATA_LENGTH{1'b0}};
        end else begin
            read_data2 = regs_q[read_reg2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int checks;
    int failures;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_reg1 = 5'd2;
        read_reg2 = 5'd3;
        #1;
        checks++;
        if (read_data1 !== 32'h7FFF_EFFC) begin
            failures++;
            $display("FAIL reset_sp got=%h exp=%h", read_data1, 32'h7FFF_EFFC);
        end
        checks++;
        if (read_data2 !== 32'h1000_8000) begin
            failures++;
            $display("FAIL reset_gp got=%h exp=%h", read_data2, 32'h1000_8000);
        end
        for (int i = 0; i < 32; i++) begin
            if (i != 2 && i != 3) begin
                read_reg1 = 5'(i);
                read_reg2 = 5'(i);
                #1;
                checks++;
                if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_sweep x%0d got1=%h got2=%h exp=0", i, read_data1, read_data2);
                end
            end
        end
    endtask

    task automatic test_basic_write();
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'hDEAD_BEEF;
        read_reg1  = 5'd5;
        #1;
        checks++;
        if (read_data1 !== 32'h0) begin
            failures++;
            $display("FAIL write_before_edge got=%h exp=%h", read_data1, 32'h0);
        end
        tick();
        checks++;
        if (read_data1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL write_after_edge got=%h exp=%h", read_data1, 32'hDEAD_BEEF);
        end
        write_reg  = 5'd31;
        write_data = 32'h0000_0001;
        read_reg2  = 5'd31;
        tick();
        reg_write = 1'b0;
        checks++;
        if (read_data2 !== 32'h0000_0001) begin
            failures++;
            $display("FAIL write_x31 got=%h exp=%h", read_data2, 32'h1);
        end
        checks++;
        if (read_data1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL x5_unchanged got=%h exp=%h", read_data1, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_x0_protect();
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFF_FFFF;
        tick();
        reg_write = 1'b0;
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        #1;
        checks++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            failures++;
            $display("FAIL x0_protect got1=%h got2=%h exp=0", read_data1, read_data2);
        end
    endtask

    task automatic test_write_disable();
        reg_write  = 1'b0;
        write_reg  = 5'd7;
        write_data = 32'h1234_5678;
        read_reg1  = 5'd7;
        read_reg2  = 5'd5;
        tick();
        checks++;
        if (read_data1 !== 32'h0) begin
            failures++;
            $display("FAIL write_disable got=%h exp=%h", read_data1, 32'h0);
        end
        checks++;
        if (read_data2 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL disable_x5_kept got=%h exp=%h", read_data2, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_reset_priority();
        rst        = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd2;
        write_data = 32'hAAAA_AAAA;
        tick();
        rst       = 1'b0;
        reg_write = 1'b0;
        read_reg1 = 5'd2;
        read_reg2 = 5'd5;
        #1;
        checks++;
        if (read_data1 !== 32'h7FFF_EFFC) begin
            failures++;
            $display("FAIL reset_over_write got=%h exp=%h", read_data1, 32'h7FFF_EFFC);
        end
        checks++;
        if (read_data2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_clears_x5 got=%h exp=%h", read_data2, 32'h0);
        end
        reg_write  = 1'b1;
        write_reg  = 5'd10;
        write_data = 32'h0000_0055;
        read_reg1  = 5'd10;
        tick();
        reg_write = 1'b0;
        checks++;
        if (read_data1 !== 32'h0000_0055) begin
            failures++;
            $display("FAIL x10_written got=%h exp=%h", read_data1, 32'h55);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (read_data1 !== 32'h0) begin
            failures++;
            $display("FAIL x10_reset got=%h exp=%h", read_data1, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        reg_write  = 1'b1;
        write_reg  = 5'd8;
        write_data = 32'h0000_0011;
        read_reg1  = 5'd8;
        read_reg2  = 5'd8;
        tick();
        write_data = 32'h0000_0022;
        #1;
        checks++;
        if (read_data1 !== 32'h11 || read_data2 !== 32'h11) begin
            failures++;
            $display("FAIL overwrite_old got1=%h got2=%h exp=%h", read_data1, read_data2, 32'h11);
        end
        tick();
        reg_write = 1'b0;
        checks++;
        if (read_data1 !== 32'h22 || read_data2 !== 32'h22) begin
            failures++;
            $display("FAIL overwrite_new got1=%h got2=%h exp=%h", read_data1, read_data2, 32'h22);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'h0;
        read_reg1  = 5'd0;
        read_reg2  = 5'd0;
        test_reset();
        test_basic_write();
        test_x0_protect();
        test_write_disable();
        test_reset_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
